// File: rtl/ifft_pkg.sv
// rtl/ifft_pkg.sv - shared types and helpers for the IFFT ping-pong sample store
// Purpose : bank-state encoding, default frame depth, address bit-reversal helper.
// Ports   : none (package).
package ifft_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;
  localparam int MAX_AW         = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Reverses the low 'width' bits of k; bits above 'width' come back as zero.
  function automatic logic [MAX_AW-1:0] bitrev(input logic [MAX_AW-1:0] k, input int width);
    logic [MAX_AW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_AW; i++) begin
      if (i < width) r[i] = k[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ifft_ram_bank.sv
// rtl/ifft_ram_bank.sv - one sample bank: synchronous write port, registered read port
// Purpose : stores 2**AW words of WIDTH bits. Read is read-first against a write to the
//           same address in the same cycle; rdata holds its value when re is low.
// Ports   : clk, rst (async active-low, clears rdata only), we/waddr/wdata write port,
//           re/raddr read request, rdata registered read data.
module ifft_ram_bank #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ifft_pingpong_ram.sv
// rtl/ifft_pingpong_ram.sv - double-buffered complex sample store between mapper and IFFT core
// Purpose : mapper fills one bank (optionally bit-reversed) while the core reads and writes
//           back in place on the other bank; banks swap on frame completion / rd_release.
// Ports   : clk, rst (async active-low)
//           writer : wr_valid, wr_ready, wr_re, wr_im
//           reader : frame_rdy, rd_en, rd_add, rd_valid, rd_re, rd_im
//           in-place write-back : wb_en, wb_add, wb_re, wb_im
//           rd_release : core done with the reader bank
module ifft_pingpong_ram
  import ifft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int BITREV_WR  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_re,
  input  logic [DATA_WIDTH-1:0] wr_im,
  output logic                  frame_rdy,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_add,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_re,
  output logic [DATA_WIDTH-1:0] rd_im,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_add,
  input  logic [DATA_WIDTH-1:0] wb_re,
  input  logic [DATA_WIDTH-1:0] wb_im,
  input  logic                  rd_release
);

  localparam int W = 2 * DATA_WIDTH;

  bank_state_t           state_q [2];
  bank_state_t           state_d [2];
  logic                  wsel_q, wsel_d;
  logic                  rsel_q, rsel_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                  rd_sel_q;

  logic                  wr_acc, rd_acc, wb_acc, rel_acc;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [1:0]            bank_we;
  logic [1:0]            bank_re;
  logic [ADDR_WIDTH-1:0] bank_waddr [2];
  logic [W-1:0]          bank_wdata [2];
  logic [W-1:0]          bank_rdata [2];

  // ---------------- outputs derived from registered state ----------------
  always_comb begin
    wr_ready = (state_q[wsel_q] != BANK_FULL);
    frame_rdy = (state_q[rsel_q] == BANK_FULL);
  end

  assign wr_acc  = wr_valid & wr_ready;
  assign rd_acc  = rd_en & frame_rdy;
  assign wb_acc  = wb_en & frame_rdy;
  assign rel_acc = rd_release & frame_rdy;

  assign wr_addr = (BITREV_WR != 0) ? ADDR_WIDTH'(bitrev(MAX_AW'(wcnt_q), ADDR_WIDTH)) : wcnt_q;

  // ---------------- next-state ----------------
  // Release and final write always target different banks (the writer cannot
  // accept into a FULL bank), so both updates may land in the same cycle.
  always_comb begin
    state_d = state_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    wcnt_d  = wcnt_q;
    if (rel_acc) begin
      state_d[rsel_q] = BANK_EMPTY;
      rsel_d          = ~rsel_q;
    end
    if (wr_acc) begin
      if (&wcnt_q) begin
        state_d[wsel_q] = BANK_FULL;
        wcnt_d          = '0;
        wsel_d          = ~wsel_q;
      end else begin
        state_d[wsel_q] = BANK_FILLING;
        wcnt_d          = wcnt_q + 1'b1;
      end
    end
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q[0] <= BANK_EMPTY;
      state_q[1] <= BANK_EMPTY;
      wsel_q     <= 1'b0;
      rsel_q     <= 1'b0;
      wcnt_q     <= '0;
      rd_valid   <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wsel_q   <= wsel_d;
      rsel_q   <= rsel_d;
      wcnt_q   <= wcnt_d;
      rd_valid <= rd_acc;
      // Remembers which bank produced the last read so rd_re/rd_im hold across
      // idle cycles and bank swaps.
      if (rd_acc) rd_sel_q <= rsel_q;
    end
  end

  // ---------------- bank port muxing ----------------
  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam bit BSEL = (b == 1);

    always_comb begin
      if (wb_acc && (rsel_q == BSEL)) begin
        bank_we[b]    = 1'b1;
        bank_waddr[b] = wb_add;
        bank_wdata[b] = {wb_re, wb_im};
      end else begin
        bank_we[b]    = wr_acc && (wsel_q == BSEL);
        bank_waddr[b] = wr_addr;
        bank_wdata[b] = {wr_re, wr_im};
      end
      bank_re[b] = rd_acc && (rsel_q == BSEL);
    end

    ifft_ram_bank #(
      .WIDTH (W),
      .AW    (ADDR_WIDTH)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we[b]),
      .waddr (bank_waddr[b]),
      .wdata (bank_wdata[b]),
      .re    (bank_re[b]),
      .raddr (rd_add),
      .rdata (bank_rdata[b])
    );
  end

  assign {rd_re, rd_im} = bank_rdata[rd_sel_q];

endmodule
